// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : two-port (fetch A / data B) arbiter onto one shared memory,
//               B-priority with a starvation limit that forces A ahead.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read_a,
  input  logic [15:0] address_a,
  output logic        resp_a,
  output logic [15:0] rdata_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  input  logic [1:0]  wmask_b,
  output logic        resp_b,
  output logic [15:0] rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_wmask,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata
);

  localparam int c_CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_CNT_W-1:0] r_starve_cnt;
  logic [15:0]        r_addr;
  logic [15:0]        r_wdata;
  logic [1:0]         r_wmask;
  logic               r_write;
  logic               w_req_b;
  logic               w_grant_a;
  logic               w_grant_b;
  logic               w_serving;

  assign w_req_b = read_b | write_b;

  always_comb begin
    w_state_next = r_state;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    case (r_state)
      IDLE: begin
        if (read_a && (!w_req_b || (r_starve_cnt == c_LIMIT))) begin
          w_grant_a    = 1'b1;
          w_state_next = SERVE_A;
        end else if (w_req_b) begin
          w_grant_b    = 1'b1;
          w_state_next = SERVE_B;
        end
      end
      SERVE_A, SERVE_B: begin
        if (pmem_resp) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Winner's command is captured on the grant edge so requester changes
  // during service cannot disturb the memory bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_write      <= 1'b0;
    end else if (w_grant_a) begin
      r_starve_cnt <= '0;
      r_addr       <= address_a;
      r_wdata      <= '0;
      r_wmask      <= 2'b11;
      r_write      <= 1'b0;
    end else if (w_grant_b) begin
      r_addr  <= address_b;
      r_wdata <= wdata_b;
      r_wmask <= wmask_b;
      r_write <= write_b;
      if (read_a && (r_starve_cnt != c_LIMIT)) r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_serving    = (r_state == SERVE_A) || (r_state == SERVE_B);
  assign pmem_read    = w_serving & ~r_write;
  assign pmem_write   = w_serving & r_write;
  assign pmem_address = w_serving ? r_addr  : 16'h0000;
  assign pmem_wdata   = w_serving ? r_wdata : 16'h0000;
  assign pmem_wmask   = w_serving ? r_wmask : 2'b00;

  assign resp_a  = (r_state == SERVE_A) & pmem_resp;
  assign rdata_a = (r_state == SERVE_A) ? pmem_rdata : 16'h0000;
  assign resp_b  = (r_state == SERVE_B) & pmem_resp;
  assign rdata_b = (r_state == SERVE_B) ? pmem_rdata : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed scenarios plus a randomized run against a
//                  transaction-level reference model.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read_a = 1'b0;
  logic [15:0] address_a = '0;
  logic        resp_a;
  logic [15:0] rdata_a;
  logic        read_b = 1'b0;
  logic        write_b = 1'b0;
  logic [15:0] address_b = '0;
  logic [15:0] wdata_b = '0;
  logic [1:0]  wmask_b = '0;
  logic        resp_b;
  logic [15:0] rdata_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic        pmem_resp = 1'b0;
  logic [15:0] pmem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write_b(write_b), .address_b(address_b), .wdata_b(wdata_b),
    .wmask_b(wmask_b), .resp_b(resp_b), .rdata_b(rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [69:0] outs();
    return {resp_a, rdata_a, resp_b, rdata_b, pmem_read, pmem_write,
            pmem_address, pmem_wdata, pmem_wmask};
  endfunction

  task automatic clear_inputs();
    read_a = 0; address_a = '0; read_b = 0; write_b = 0;
    address_b = '0; wdata_b = '0; wmask_b = '0; pmem_resp = 0; pmem_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    reset_n = 0;
    read_a = 1; write_b = 1; pmem_resp = 1; pmem_rdata = 16'hFFFF;
    address_a = 16'h1111; address_b = 16'h2222; wdata_b = 16'h3333; wmask_b = 2'b11;
    #1;
    n_cmp++;
    if (outs() !== 70'd0) begin
      n_err++; $display("FAIL reset_async_outputs: got %h want 0", outs());
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (outs() !== 70'd0) begin
      n_err++; $display("FAIL reset_held_outputs: got %h want 0", outs());
    end
    clear_inputs();
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    do_reset();
    read_a = 1; address_a = 16'h0040;
    @(negedge clk);
    n_cmp++;
    if (pmem_read !== 1'b0) begin
      n_err++; $display("FAIL read_pre_grant: pmem_read=%b want 0", pmem_read);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_write, pmem_address, resp_a} !== {1'b1, 1'b0, 16'h0040, 1'b0}) begin
      n_err++; $display("FAIL read_cycle1: rd=%b wr=%b addr=%h resp_a=%b want 1 0 0040 0",
                        pmem_read, pmem_write, pmem_address, resp_a);
    end
    @(posedge clk); #1;
    pmem_resp = 1; pmem_rdata = 16'h1234; read_a = 0;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_address, resp_a, rdata_a, resp_b, rdata_b} !==
        {1'b1, 16'h0040, 1'b1, 16'h1234, 1'b0, 16'h0000}) begin
      n_err++; $display("FAIL read_cycle2: rd=%b addr=%h resp_a=%b rdata_a=%h resp_b=%b rdata_b=%h want 1 0040 1 1234 0 0000",
                        pmem_read, pmem_address, resp_a, rdata_a, resp_b, rdata_b);
    end
    @(posedge clk); #1;
    pmem_resp = 0;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_write, pmem_address, resp_a} !== 19'd0) begin
      n_err++; $display("FAIL read_idle_after: rd=%b wr=%b addr=%h resp_a=%b want all 0",
                        pmem_read, pmem_write, pmem_address, resp_a);
    end
  endtask

  task automatic test_contention();
    do_reset();
    read_a = 1; address_a = 16'h0A0A;
    write_b = 1; address_b = 16'h0100; wdata_b = 16'hBEEF; wmask_b = 2'b01;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask} !==
        {1'b0, 1'b1, 16'h0100, 16'hBEEF, 2'b01}) begin
      n_err++; $display("FAIL contend_b_first: rd=%b wr=%b addr=%h wdata=%h mask=%b want 0 1 0100 beef 01",
                        pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask);
    end
    @(posedge clk); #1;
    pmem_resp = 1; write_b = 0;
    @(negedge clk);
    n_cmp++;
    if ({resp_b, resp_a} !== 2'b10) begin
      n_err++; $display("FAIL contend_resp_b: resp_b=%b resp_a=%b want 1 0", resp_b, resp_a);
    end
    @(posedge clk); #1;
    pmem_resp = 0;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      n_err++; $display("FAIL contend_idle_gap: rd=%b wr=%b want 0 0", pmem_read, pmem_write);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wmask} !== {1'b1, 1'b0, 16'h0A0A, 2'b11}) begin
      n_err++; $display("FAIL contend_a_next: rd=%b wr=%b addr=%h mask=%b want 1 0 0a0a 11",
                        pmem_read, pmem_write, pmem_address, pmem_wmask);
    end
    @(posedge clk); #1;
    pmem_resp = 1; read_a = 0;
    @(posedge clk); #1;
    pmem_resp = 0;
  endtask

  task automatic test_starvation();
    byte exp_order [10] = '{"B","B","B","B","A","B","B","B","B","A"};
    byte got_order [$];
    int  cycles = 0;
    do_reset();
    read_a = 1; address_a = 16'hA000;
    read_b = 1; address_b = 16'hB000;
    pmem_resp = 1;
    while (got_order.size() < 10 && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (pmem_read) begin
        if (pmem_address == 16'hA000) begin
          got_order.push_back("A");
          n_cmp++;
          if (dut.r_starve_cnt !== '0) begin
            n_err++; $display("FAIL starve_clear: cnt=%0d want 0 after A grant", dut.r_starve_cnt);
          end
        end else begin
          got_order.push_back("B");
        end
      end
    end
    n_cmp++;
    if (got_order.size() != 10) begin
      n_err++; $display("FAIL starve_timeout: got %0d grants want 10", got_order.size());
    end
    for (int i = 0; i < got_order.size(); i++) begin
      n_cmp++;
      if (got_order[i] !== exp_order[i]) begin
        n_err++; $display("FAIL starve_order[%0d]: got %s want %s", i, got_order[i], exp_order[i]);
      end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_b = 1; address_b = 16'h0200; wdata_b = 16'h5555; wmask_b = 2'b11;
    @(posedge clk); #1;
    write_b = 0;
    @(negedge clk);
    n_cmp++;
    if (pmem_write !== 1'b1) begin
      n_err++; $display("FAIL abort_pre: pmem_write=%b want 1", pmem_write);
    end
    #2 reset_n = 0;
    #1;
    n_cmp++;
    if ({pmem_write, pmem_read, pmem_address} !== 18'd0) begin
      n_err++; $display("FAIL abort_async: wr=%b rd=%b addr=%h want 0 0 0000",
                        pmem_write, pmem_read, pmem_address);
    end
    pmem_resp = 1;
    #1;
    n_cmp++;
    if (resp_b !== 1'b0) begin
      n_err++; $display("FAIL abort_no_resp: resp_b=%b want 0", resp_b);
    end
    @(posedge clk);
    @(negedge clk);
    pmem_resp = 0; reset_n = 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (outs() !== 70'd0) begin
      n_err++; $display("FAIL abort_idle_after: got %h want 0", outs());
    end
    read_a = 1; address_a = 16'h0777;
    @(posedge clk); #1;
    read_a = 0;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_address} !== {1'b1, 16'h0777}) begin
      n_err++; $display("FAIL abort_restart: rd=%b addr=%h want 1 0777", pmem_read, pmem_address);
    end
    @(posedge clk); #1;
    pmem_resp = 1;
    @(posedge clk); #1;
    pmem_resp = 0;
  endtask

  task automatic test_rw_and_idle_resp();
    do_reset();
    read_b = 1; write_b = 1; address_b = 16'h0300; wdata_b = 16'hCAFE; wmask_b = 2'b10;
    @(posedge clk); #1;
    read_b = 0; write_b = 0;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_write, pmem_wdata, pmem_wmask} !== {1'b0, 1'b1, 16'hCAFE, 2'b10}) begin
      n_err++; $display("FAIL rw_is_write: rd=%b wr=%b wdata=%h mask=%b want 0 1 cafe 10",
                        pmem_read, pmem_write, pmem_wdata, pmem_wmask);
    end
    @(posedge clk); #1;
    pmem_resp = 1;
    @(negedge clk);
    n_cmp++;
    if (resp_b !== 1'b1) begin
      n_err++; $display("FAIL rw_resp: resp_b=%b want 1", resp_b);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if ({resp_a, resp_b, pmem_read, pmem_write} !== 4'b0000) begin
        n_err++; $display("FAIL idle_resp_ignored[%0d]: resp_a=%b resp_b=%b rd=%b wr=%b want 0 0 0 0",
                          i, resp_a, resp_b, pmem_read, pmem_write);
      end
    end
    @(posedge clk); #1;
    pmem_resp = 0;
  endtask

  task automatic test_drop_b();
    do_reset();
    read_b = 1; address_b = 16'h0400;
    @(posedge clk); #1;
    read_b = 0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_address, resp_b} !== {1'b1, 16'h0400, 1'b0}) begin
      n_err++; $display("FAIL drop_b_holds: rd=%b addr=%h resp_b=%b want 1 0400 0",
                        pmem_read, pmem_address, resp_b);
    end
    @(posedge clk); #1;
    pmem_resp = 1; pmem_rdata = 16'h7777;
    @(negedge clk);
    n_cmp++;
    if ({resp_b, rdata_b, resp_a, rdata_a} !== {1'b1, 16'h7777, 1'b0, 16'h0000}) begin
      n_err++; $display("FAIL drop_b_resp: resp_b=%b rdata_b=%h resp_a=%b rdata_a=%h want 1 7777 0 0000",
                        resp_b, rdata_b, resp_a, rdata_a);
    end
    @(posedge clk); #1;
    pmem_resp = 0;
  endtask

  // Reference: at most one transaction in flight; a grant picks a winner
  // from the request levels and copies its command; pmem_resp retires it.
  task automatic test_random();
    int          owner = 0;   // 0 none, 1 A, 2 B
    int          starve = 0;
    logic [15:0] t_addr = '0, t_wdata = '0;
    logic [1:0]  t_mask = '0;
    bit          t_write = 0;
    logic [69:0] exp_v;
    int          bad = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      read_a     = ($urandom_range(0, 99) < 60);
      read_b     = ($urandom_range(0, 99) < 40);
      write_b    = ($urandom_range(0, 99) < 40);
      address_a  = 16'($urandom);
      address_b  = 16'($urandom);
      wdata_b    = 16'($urandom);
      wmask_b    = 2'($urandom);
      pmem_resp  = ($urandom_range(0, 99) < 35);
      pmem_rdata = 16'($urandom);
      @(negedge clk);
      exp_v = {owner == 1 && pmem_resp, (owner == 1) ? pmem_rdata : 16'h0,
               owner == 2 && pmem_resp, (owner == 2) ? pmem_rdata : 16'h0,
               owner != 0 && !t_write, owner != 0 && t_write,
               (owner != 0) ? t_addr : 16'h0, (owner != 0) ? t_wdata : 16'h0,
               (owner != 0) ? t_mask : 2'b00};
      n_cmp++;
      if (outs() !== exp_v) begin
        n_err++;
        if (bad < 10) $display("FAIL random[%0d]: got %h want %h", cyc, outs(), exp_v);
        bad++;
      end
      @(posedge clk);
      if (owner == 0) begin
        if (read_a && (!(read_b || write_b) || starve == STARVE_LIMIT)) begin
          owner = 1; t_addr = address_a; t_wdata = 16'h0; t_mask = 2'b11; t_write = 0;
          starve = 0;
        end else if (read_b || write_b) begin
          owner = 2; t_addr = address_b; t_wdata = wdata_b; t_mask = wmask_b; t_write = write_b;
          if (read_a && starve < STARVE_LIMIT) starve++;
        end
      end else if (pmem_resp) begin
        owner = 0;
      end
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_starvation();
    test_reset_mid();
    test_rw_and_idle_resp();
    test_drop_b();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
